// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and
// instruction memory. The fetch unit drives the request side (master).
// The memory returns the word on the response side (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches one instruction word at a time
// from instruction memory, and presents it to decode with a valid flag.
// The next PC is chosen from decode's jump/branch outcome, or from an
// external redirect.
//
// Optional build macro FETCH_PERF_CNT_EN adds two counters:
//   fetch_count - accepted fetches
//   stall_count - VALID cycles held by stall
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | request outstanding at pc, waiting for imem_ready
// VALID    | instr holds a live instruction for decode, no request out
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                stall,
    input  logic                branch,
    input  logic                zero,
    input  logic [31:0]         branch_offset,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

    logic [0:0]  state;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic [31:0] next_pc;
    logic        fetch_accept;
    logic        unused_bits;

    // Low address bits are forced to zero everywhere a PC is loaded.
    // The discarded bits are collected here only so they count as consumed.
    assign unused_bits = ^{redirect_pc[1:0], branch_offset[31:30], RESET_PC[1:0]};

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};

    // A memory response only counts in FETCH when no reset or redirect
    // is overriding the cycle.
    assign fetch_accept  = (state == ST_FETCH) && imem.imem_ready && !redirect;

    // next_pc priority: jump, then taken branch, then sequential
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_addr;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

    // Request is combinationally suppressed while reset is asserted
    always_comb begin
        imem.imem_req  = (state == ST_FETCH) && !reset;
        imem.imem_addr = pc;
        instr_valid    = (state == ST_VALID);
        opcode         = instr[31:26];
    end

    // PC, captured instruction and FETCH/VALID sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= {RESET_PC[31:2], 2'b00};
            instr <= 32'h0000_0000;
            state <= ST_FETCH;
        end else if (redirect) begin
            // Redirect drops any response arriving in the same cycle
            pc    <= {redirect_pc[31:2], 2'b00};
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        instr <= imem.imem_rdata;
                        state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        pc    <= {next_pc[31:2], 2'b00};
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters; both wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'h0000_0000;
            stall_count <= 32'h0000_0000;
        end else begin
            if (fetch_accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == ST_VALID) && stall && !redirect) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = fetch_accept;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. It runs directed scenarios, then
// randomized cycles. Expected values come from a behavioural model
// that stores the PC, the valid flag and the held instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        branch_offset = '0; jump = 1'b0; jump_target = '0;
        redirect = 1'b0; redirect_pc = '0;
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    endtask

    task automatic check_outputs();
        chk("imem_req",  {31'd0, imem.imem_req}, {31'd0, !reset && !m_valid});
        chk("imem_addr", imem.imem_addr, m_pc);
        chk("pc",        pc, m_pc);
        chk("pc_plus4",  pc_plus4, m_pc + 32'd4);
        chk("valid",     {31'd0, instr_valid}, {31'd0, m_valid});
        chk("instr",     instr, m_instr);
        chk("opcode",    {26'd0, opcode}, {26'd0, m_instr[31:26]});
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("stall_count", stall_count, m_sc);
`endif
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_update();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_fc = 0; m_sc = 0;
        end else if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!m_valid) begin
            if (imem.imem_ready) begin
                m_instr = imem.imem_rdata;
                m_valid = 1'b1;
                m_fc = m_fc + 1;
            end
        end else if (stall) begin
            m_sc = m_sc + 1;
        end else begin
            if (jump)
                m_pc = {p4[31:28], jump_target, 2'b00};
            else if (branch && zero)
                m_pc = p4 + branch_offset * 4;
            else
                m_pc = p4;
            m_valid = 1'b0;
        end
    endtask

    // Inputs are driven just after a falling edge. Outputs are checked 1
    // time unit later. The model steps, then the task waits for the next
    // falling edge.
    task automatic step();
        #1;
        check_outputs();
        model_update();
        @(negedge clk);
    endtask

    task automatic fetch_word(input logic [31:0] w);
        imem.imem_ready = 1'b1; imem.imem_rdata = w;
        step();
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect = 1'b1; redirect_pc = a;
        step();
        redirect = 1'b0; redirect_pc = '0;
    endtask

    task automatic advance(input logic b, input logic z, input logic [31:0] off,
                           input logic j, input logic [25:0] jt);
        stall = 1'b0; branch = b; zero = z; branch_offset = off; jump = j; jump_target = jt;
        step();
        branch = 1'b0; zero = 1'b0; branch_offset = '0; jump = 1'b0; jump_target = '0;
    endtask

    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    initial begin
        m_pc = 0; m_valid = 0; m_instr = 0; m_fc = 0; m_sc = 0;
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);

        // Reset release, memory answers one cycle after the request
        reset = 1'b0;
        #1;
        chk("t1_req", {31'd0, imem.imem_req}, 32'd1);
        chk("t1_addr0", imem.imem_addr, 32'h0);
        step();
        fetch_word(32'h8C22_0004);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_opcode", {26'd0, opcode}, 32'h23);
        advance(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("t1_next_addr", imem.imem_addr, 32'h4);

        // Branch taken and not taken from pc=0x10
        redirect_to(32'h0000_0010);
        fetch_word(32'h1000_FFFE);
        chk("br_opcode", {26'd0, opcode}, 32'h04);
        advance(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
        chk("br_taken", imem.imem_addr, 32'h0000_000C);
        redirect_to(32'h0000_0010);
        fetch_word(32'h1000_FFFE);
        advance(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 26'h0);
        chk("br_not_taken", imem.imem_addr, 32'h0000_0014);

        // Jump wins over a taken branch
        redirect_to(32'h4000_0008);
        fetch_word(32'h0800_0100);
        advance(1'b1, 1'b1, 32'h0000_0040, 1'b1, 26'h0000100);
        chk("jump", imem.imem_addr, 32'h4000_0400);

        // Stall holds for three cycles
        fetch_word(32'h0123_4567);
        hold_pc = pc; hold_instr = instr;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, hold_pc);
            chk("stall_instr", instr, hold_instr);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem.imem_req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("stall_release", pc, hold_pc + 32'd4);

        // Redirect collides with a memory response
        hold_instr = instr;
        imem.imem_ready = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0; redirect_pc = '0;
        chk("redir_instr", instr, hold_instr);
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_addr", imem.imem_addr, 32'h0000_0100);

        // Reset mid-fetch with a response present
        reset = 1'b1;
        step();
        imem.imem_ready = 1'b0; imem.imem_rdata = '0;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_req", {31'd0, imem.imem_req}, 32'd0);
        reset = 1'b0;
        step();

        // Wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        fetch_word(32'h0000_0000);
        chk("wrap_p4", pc_plus4, 32'h0);
        advance(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("wrap_addr", imem.imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            fetch_word(32'h1111_0000 + i);
            if (i < 2) begin
                stall = 1'b1; step(); stall = 1'b0;
            end
            advance(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        end
        chk("perf_fetch", fetch_count, 32'd5);
        chk("perf_stall", stall_count, 32'd2);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_pc     = $urandom;
            stall           = ($urandom_range(0, 1) == 0);
            branch          = $urandom_range(0, 1);
            zero            = $urandom_range(0, 1);
            branch_offset   = ($urandom_range(0, 1) == 0) ? $urandom : $signed(32'($urandom_range(0, 64))) - 32;
            jump            = ($urandom_range(0, 3) == 0);
            jump_target     = 26'($urandom);
            imem.imem_ready = ($urandom_range(0, 2) == 0);
            imem.imem_rdata = $urandom;
            step();
        end
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side producer of the opcode and instruction word consumed by the main control unit decoder.
- Holds the PC and issues requests to instruction memory with a ready handshake.
- Presents one instruction at a time, with a valid flag, to decode.
- Takes back the decoder's Branch/Jump outcome, plus ALU zero, to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_ready  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  instruction word from memory.
- instr  output  32  registered instruction presented to decode.
- opcode  output  6  instr[31:26], the control unit opcode input.
- instr_valid  output  1  instr/opcode hold a live instruction.
- pc  output  32  address of the current or in-flight instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- stall  input  1  hazard hold; freezes the current instruction.
- branch  input  1  Branch control signal from the decoder.
- zero  input  1  ALU zero flag for the current instruction.
- branch_offset  input  32  sign-extended immediate; word offset.
- jump  input  1  jump control signal from the decoder.
- jump_target  input  26  instr[25:0] field for j-format.
- redirect  input  1  external PC override (exception/restart).
- redirect_pc  input  32  target PC for redirect; bits [1:0] ignored.

Behaviour:
- Reset (reset=1 at a clk edge):
  - pc=RESET_PC, state=FETCH.
  - instr=0, opcode=0, instr_valid=0.
  - imem_req=0 while reset is high.
  - imem_req=1 in the first cycle after reset is low.
  - Reset mid-fetch abandons the request; any imem_ready in that cycle is ignored.
- States: FETCH and VALID.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ready=1: instr<=imem_rdata, state<=VALID.
  - instr_valid rises the cycle after imem_ready; latency is 1 cycle from ready.
  - imem_req stays high until imem_ready. No timeout.
- VALID:
  - imem_req=0, instr_valid=1.
  - instr and opcode stay stable while state is VALID.
  - If stall=1: hold. pc, instr and state are unchanged.
  - If stall=0: pc<=next_pc, state<=FETCH, instr_valid<=0 next cycle.
  - Each instruction is valid for at least 1 cycle.
- next_pc priority, evaluated only in VALID with stall=0:
  - 1. jump=1 -> {pc_plus4[31:28], jump_target, 2'b00}.
  - 2. branch=1 and zero=1 -> pc_plus4 + (branch_offset<<2), truncated to 32 bits.
  - 3. otherwise -> pc_plus4.
  - Adds wrap modulo 2^32, e.g. pc=32'hFFFF_FFFC -> pc_plus4=0.
  - branch=1 with zero=0 falls through to pc_plus4.
- redirect=1 (highest priority after reset, in any state):
  - pc<={redirect_pc[31:2],2'b00}, state<=FETCH, instr_valid<=0.
  - Overrides stall, jump and branch.
  - If imem_ready=1 in the same FETCH cycle, that response is discarded; instr is not updated.
- Addresses: imem_addr[1:0] and pc[1:0] are always 0.
- opcode is always equal to instr[31:26]; no separate register.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0.
  - Increments by 1 on every accepted fetch (FETCH and imem_ready=1 and redirect=0).
  - Wraps 32'hFFFF_FFFF -> 0.
  - Adds output stall_count [31:0], reset to 0; increments each cycle in VALID with stall=1 and redirect=0.
- Not defined:
  - Neither port exists; no counter logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, memory ready 1 cycle after each request, returning 32'h8C22_0004 -> imem_addr=0, instr_valid high 1 cycle after ready, opcode=6'h23, next imem_addr=4.
- Branch taken: pc=32'h10, instr opcode 6'h04, branch=1, zero=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=32'h0C. Same stimulus with zero=0 -> next imem_addr=32'h14.
- Jump: pc=32'h4000_0008, jump=1, jump_target=26'h0000100 -> next imem_addr=32'h4000_0400, overriding branch=1/zero=1 asserted in the same cycle.
- Stall: hold stall=1 for 3 cycles in VALID -> instr, opcode, pc and instr_valid=1 unchanged and imem_req=0 throughout. Drop stall -> pc advances by 4 on the next edge.
- Redirect during fetch: memory asserts imem_ready with 32'hDEAD_BEEF in the same cycle as redirect=1, redirect_pc=32'h0000_0103 -> instr not updated, instr_valid=0, next imem_addr=32'h100. Then reset=1 mid-fetch -> pc=RESET_PC, all outputs at reset values.
- Wrap plus FETCH_PERF_CNT_EN: pc=32'hFFFF_FFFC, stall=0, no branch/jump -> next imem_addr=0. With the macro defined, 5 fetches and 2 stall cycles -> fetch_count=5, stall_count=2.
